// File: rtl/ifetch_unit.sv
// Instruction fetch: holds PC, fetches over req/ack, waits for next-PC select.
// Ports: clk/rst_n, imem req/addr/ack/rdata, npc_op/valid/rs_data, instr/pc/status out.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  npc_op,
  input  logic        npc_valid,
  input  logic [31:0] rs_data,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    S_START,
    S_FETCH,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic        fault_q, fault_d;
  logic [31:0] ret_q, ret_d;

  logic [31:0] seq_pc;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic        jr_bad;

  assign seq_pc = pc_q + 32'd4;
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jr_bad = (npc_op == 2'b11) && (rs_data[1:0] != 2'b00);

  always_comb begin
    next_pc = seq_pc;
    case (npc_op)
      2'b00:   next_pc = seq_pc;
      2'b01:   next_pc = seq_pc + br_off;
      2'b10:   next_pc = {seq_pc[31:28], instr_q[25:0], 2'b00};
      2'b11:   next_pc = rs_data;
      default: next_pc = seq_pc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    fault_d = fault_q;
    ret_d   = ret_q;
    case (state_q)
      S_START: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (npc_valid) begin
          valid_d = 1'b0;
          if (jr_bad) begin
            // Misaligned register target: park until reset.
            fault_d = 1'b1;
            req_d   = 1'b0;
            state_d = S_FAULT;
          end else begin
            pc_d    = next_pc;
            req_d   = 1'b1;
            ret_d   = ret_q + 32'd1;
            state_d = S_FETCH;
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: state_d = S_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_START;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
      ret_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      fault_q <= fault_d;
      ret_q   <= ret_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign pc          = pc_q;
  assign pc_plus4    = seq_pc;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
  assign retired     = ret_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed table, hand sequences, random stream
// checked against a transaction-level PC model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  npc_op;
  logic        npc_valid;
  logic [31:0] rs_data;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        fault;
  logic [31:0] retired;

  ifetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .npc_op(npc_op), .npc_valid(npc_valid), .rs_data(rs_data),
    .instr(instr), .op(op), .funct(funct),
    .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic [31:0] m_instr;

  typedef struct {
    logic [31:0] rdata;
    int          waits;
    logic [1:0]  nop;
    logic [31:0] rs;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_next(logic [31:0] cur,
      logic [31:0] iw, logic [1:0] sel, logic [31:0] rs);
    int off;
    off = $signed(iw[15:0]);
    case (sel)
      2'b00: return cur + 4;
      2'b01: return cur + 4 + 32'(off * 4);
      2'b10: return ((cur + 4) & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) << 2);
      default: return rs;
    endcase
  endfunction

  task automatic do_fetch(logic [31:0] rdata, int waits);
    for (int w = 0; w < waits; w++) begin
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, m_pc);
      tick();
    end
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    imem_rdata = rdata;
    tick();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    m_instr = rdata;
    chk("valid_up", {31'd0, instr_valid}, 32'd1);
    chk("instr", instr, rdata);
    chk("op", {26'd0, op}, {26'd0, rdata[31:26]});
    chk("funct", {26'd0, funct}, {26'd0, rdata[5:0]});
    chk("pc_plus4", pc_plus4, m_pc + 4);
    chk("req_low", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic do_commit(logic [1:0] sel, logic [31:0] rs, int stalls);
    for (int s = 0; s < stalls; s++) begin
      npc_valid = 1'b0;
      npc_op = 2'($urandom);
      imem_ack = 1'($urandom);
      tick();
      imem_ack = 1'b0;
      chk("stall_instr", instr, m_instr);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_pc", pc, m_pc);
    end
    npc_op = sel;
    rs_data = rs;
    npc_valid = 1'b1;
    tick();
    npc_valid = 1'b0;
    m_pc = model_next(m_pc, m_instr, sel, rs);
    m_ret = m_ret + 1;
    chk("valid_down", {31'd0, instr_valid}, 32'd0);
    chk("next_req", {31'd0, imem_req}, 32'd1);
    chk("next_pc", imem_addr, m_pc);
    chk("retired", retired, m_ret);
  endtask

  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    for (int c = 0; c < cycles; c++) tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_pc", pc, 32'h0000_3000);
    m_pc = 32'h0000_3000;
    m_ret = 0;
    m_instr = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    npc_op = 2'b00;
    npc_valid = 1'b0;
    rs_data = 32'd0;

    tbl[0] = '{32'h2008_0005, 0, 2'b00, 32'd0, 32'h0000_3000};
    tbl[1] = '{32'h0000_0000, 2, 2'b00, 32'd0, 32'h0000_3004};
    tbl[2] = '{32'h0109_5020, 1, 2'b00, 32'd0, 32'h0000_3008};
    tbl[3] = '{32'h0000_0000, 0, 2'b00, 32'd0, 32'h0000_300C};
    tbl[4] = '{32'h1000_FFFF, 0, 2'b01, 32'd0, 32'h0000_3010};
    tbl[5] = '{32'h0800_0C10, 3, 2'b10, 32'd0, 32'h0000_3010};
    tbl[6] = '{32'h03E0_0008, 0, 2'b11, 32'h0000_3100, 32'h0000_3040};

    // Reset, then START lasts one cycle.
    do_reset(3);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("start_req", {31'd0, imem_req}, 32'd1);
    chk("start_ack_ignored", {31'd0, instr_valid}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      chk("tbl_addr", imem_addr, tbl[i].exp_addr);
      do_fetch(tbl[i].rdata, tbl[i].waits);
      if (i == 0) chk("first_op", {26'd0, op}, 32'h08);
      do_commit(tbl[i].nop, tbl[i].rs, i == 3 ? 2 : 0);
      if (i == 2) chk("retired3", retired, 32'd3);
    end
    chk("jr_target", imem_addr, 32'h0000_3100);

    // Random stream against the model.
    for (int k = 0; k < 60; k++) begin
      logic [1:0] sel;
      sel = 2'($urandom);
      do_fetch($urandom, int'($urandom_range(0, 3)));
      do_commit(sel, $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 2)));
    end

    // Misaligned JR, then inputs ignored.
    do_fetch(32'h0060_0008, 0);
    npc_op = 2'b11;
    rs_data = m_pc + 32'h0000_0102;
    npc_valid = 1'b1;
    tick();
    npc_valid = 1'b0;
    chk("fault_set", {31'd0, fault}, 32'd1);
    chk("fault_valid", {31'd0, instr_valid}, 32'd0);
    chk("fault_req", {31'd0, imem_req}, 32'd0);
    chk("fault_pc", pc, m_pc);
    chk("fault_ret", retired, m_ret);
    for (int c = 0; c < 4; c++) begin
      npc_valid = 1'b1;
      npc_op = 2'($urandom);
      rs_data = 32'h0000_3200;
      imem_ack = 1'b1;
      imem_rdata = $urandom;
      tick();
      chk("fault_hold_pc", pc, m_pc);
      chk("fault_hold_req", {31'd0, imem_req}, 32'd0);
      chk("fault_hold_ret", retired, m_ret);
      chk("fault_hold_instr", instr, m_instr);
      chk("fault_sticky", {31'd0, fault}, 32'd1);
    end
    npc_valid = 1'b0;
    imem_ack = 1'b0;

    // Reset mid-fetch, late ack in START.
    do_reset(1);
    rst_n = 1'b1;
    tick();
    chk("refetch_req", {31'd0, imem_req}, 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", pc, 32'h0000_3000);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_ack_instr", instr, 32'd0);
    chk("late_ack_pc", pc, 32'h0000_3000);
    do_fetch(32'h2008_0005, 0);
    do_commit(2'b00, 32'd0, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage of the MIPS core, sitting directly upstream of the control decoder. It holds the PC, fetches one instruction at a time over a request/acknowledge instruction-memory port, and presents the instruction with its op/funct fields to decode. It then waits for the decoder's resolved next-PC selection, computes the next PC (sequential, branch, jump or register jump), and starts the next fetch.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `imem_req` out 1: fetch request, registered.
- `imem_addr` out 32: fetch address, equal to `pc`.
- `imem_ack` in 1: memory has returned data this cycle.
- `imem_rdata` in 32: instruction word, sampled when `imem_ack` is 1.
- `npc_op` in 2: next-PC select. 00 = PLUS4, 01 = BRANCH (taken), 10 = JUMP, 11 = JR.
- `npc_valid` in 1: decode/execute commits `npc_op` (and `rs_data`) for the held instruction.
- `rs_data` in 32: register jump target, used when `npc_op` is JR.
- `instr` out 32: held instruction word.
- `op` out 6: `instr[31:26]`.
- `funct` out 6: `instr[5:0]`.
- `pc` out 32: address of the held instruction.
- `pc_plus4` out 32: `pc + 4`, used as the jal/jalr link value.
- `instr_valid` out 1: `instr`, `op` and `funct` are valid.
- `fault` out 1: sticky misaligned-JR fault.
- `retired` out 32: count of committed instructions.

## Operation
- State machine has four states: START, FETCH, HOLD, FAULT.
- **Reset** (`rst_n` = 0 at an edge):
  - state = START, `pc` = `RESET_PC`.
  - `imem_req`, `instr_valid` and `fault` are 0.
  - `instr` = 0, `retired` = 0.
- **START**:
  - Moves to FETCH at the next edge and sets `imem_req` = 1.
  - `imem_ack` is ignored in this state.
- **FETCH**:
  - `imem_req` = 1 and `imem_addr` = `pc`; both stay stable until the ack.
  - At an edge with `imem_ack` = 1: `instr` <= `imem_rdata`, `instr_valid` <= 1, `imem_req` <= 0, state goes to HOLD.
  - `npc_valid` is ignored in this state.
- **HOLD**:
  - `instr` and `pc` are held and `imem_req` = 0. `imem_ack` is ignored.
  - At an edge with `npc_valid` = 1, the next PC is computed as listed below.
  - If the target is legal: `pc` <= next, `instr_valid` <= 0, `imem_req` <= 1, `retired` <= `retired` + 1, state goes to FETCH.
- **Next-PC computation.** All arithmetic is modulo 2^32.
  - PLUS4: next = `pc` + 4.
  - BRANCH: next = `pc` + 4 + (sign_extend(`instr[15:0]`) << 2).
  - JUMP: next = {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - JR: next = `rs_data`.
- **Misaligned JR.** In HOLD, if `npc_valid` = 1, `npc_op` = JR and `rs_data[1:0]` != 0:
  - `fault` <= 1, `instr_valid` <= 0, `imem_req` <= 0.
  - `pc` is unchanged and `retired` is not incremented. State goes to FAULT.
- **FAULT**: all inputs are ignored. The only exit is reset.
- `retired` wraps from 32'hFFFF_FFFF to 0.

## Timing
- A fetch request is issued one cycle after reset is released (START lasts exactly one cycle).
- The fetch presents a zero-wait acknowledge in the same cycle it requests. `imem_ack` may be asserted in that first FETCH cycle.
- Minimum throughput is 2 cycles per instruction: one FETCH cycle and one HOLD cycle.
- Each memory wait cycle adds 1 cycle. Each decode stall (HOLD with `npc_valid` = 0) adds 1 cycle.
- `instr_valid` rises on the edge that samples `imem_ack`. It falls on the edge that samples `npc_valid`.
- All outputs are registered, except that `op`, `funct`, `imem_addr` and `pc_plus4` are direct slices or sums of registers.
- If reset is asserted mid-fetch, `imem_req` drops at that edge. A late `imem_ack` arriving in START is discarded.
- Reset takes priority over every other event in the same cycle.

## Test plan
- **Reset and first fetch.** Hold `rst_n` = 0 for 3 cycles, release, ack `imem_rdata` = 32'h2008_0005 on the first FETCH cycle.
  - Required: `imem_addr` = 32'h0000_3000; `instr_valid` = 1 with `op` = 6'h08, `pc_plus4` = 32'h0000_3004.
- **Sequential stream with wait states.** Memory acks after 0, 2 and 1 wait cycles; `npc_op` = PLUS4.
  - Required: addresses 3000, 3004, 3008.
  - Required: `retired` = 3 after the third commit.
  - Required: `imem_addr` is stable during every wait cycle.
- **Taken branch.** Instruction 32'h1000_FFFF at `pc` 3010, `npc_op` = BRANCH.
  - Required: next `imem_addr` = 32'h0000_3010.
- **Jump and JR.** Instruction 32'h0800_0C10 with `npc_op` = JUMP.
  - Required: next PC = 32'h0000_3040.
  - Then JR with `rs_data` = 32'h0000_3100; required: next PC = 32'h0000_3100.
- **Misaligned JR.** JR with `rs_data` = 32'h0000_3102.
  - Required: `fault` = 1, `instr_valid` = 0, `imem_req` = 0, `pc` unchanged, `retired` unchanged.
  - Required: further `npc_valid` and `imem_ack` are ignored until reset.
- **Reset mid-fetch and decode stall.** Assert `rst_n` = 0 during a pending request, then ack in START.
  - Required: the ack is ignored and `pc` = `RESET_PC`.
  - Then hold `npc_valid` = 0 for 5 cycles in HOLD; required: `instr` is held, `imem_req` = 0, no PC change.
